// File: rtl/rfid_pkg.sv
// rtl/rfid_pkg.sv - shared constants, state types and ASCII hex helpers for the RFID frame receiver
package rfid_pkg;

  localparam logic [7:0] RFID_STX = 8'h02;
  localparam logic [7:0] RFID_ETX = 8'h03;

  typedef enum logic [1:0] {IDLE, DATA, CSUM, ETX} rfid_state_e;
  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT} uart_state_e;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
  endfunction

  // Letters of either case share the low nibble, so one offset covers both.
  function automatic logic [3:0] hex2nib(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/rfid_uart_rx.sv
// rtl/rfid_uart_rx.sv - 8N1 UART receiver with input synchroniser, mid-bit sampling and framing error detect
module rfid_uart_rx
  import rfid_pkg::*;
#(
  parameter int DIV = 10416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  logic [1:0]   sync;
  logic         rx_s;
  uart_state_e  ust, ust_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]   bit_idx;
  logic         cnt_clr, sample, done_ok, done_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx_in};
  end
  assign rx_s = sync[1];

  always_comb begin
    ust_nxt  = ust;
    cnt_clr  = 1'b0;
    sample   = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (ust)
      U_IDLE: if (!rx_s) begin
        ust_nxt = U_START;
        cnt_clr = 1'b1;
      end
      U_START: if (cnt == HALF) begin
        cnt_clr = 1'b1;
        ust_nxt = rx_s ? U_IDLE : U_DATA;
      end
      U_DATA: if (cnt == FULL) begin
        cnt_clr = 1'b1;
        sample  = 1'b1;
        if (bit_idx == 3'd7) ust_nxt = U_STOP;
      end
      U_STOP: if (cnt == FULL) begin
        if (rx_s) begin
          done_ok = 1'b1;
          ust_nxt = U_IDLE;
        end else begin
          done_err = 1'b1;
          ust_nxt  = U_WAIT;
        end
      end
      U_WAIT: if (rx_s) ust_nxt = U_IDLE;
      default: ust_nxt = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ust        <= U_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ust        <= ust_nxt;
      cnt        <= cnt_clr ? '0 : cnt + 1'b1;
      if (ust == U_START) bit_idx <= '0;
      else if (sample)    bit_idx <= bit_idx + 1'b1;
      if (sample) byte_data <= {rx_s, byte_data[7:1]};
      byte_valid <= done_ok;
      frame_err  <= done_err;
    end
  end

endmodule

// File: rtl/rfid_frame_rx.sv
// rtl/rfid_frame_rx.sv - RFID ASCII tag frame parser with XOR checksum; RFID_FRAME_RX_TIMEOUT_EN adds an inter-byte gap timeout
module rfid_frame_rx
  import rfid_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 9600,
  parameter int ID_BYTES    = 5
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  rx_in,
  input  logic                  tag_ack,
  output logic [8*ID_BYTES-1:0] tag_id,
  output logic                  tag_new,
  output logic [7:0]            err_cnt,
  output logic                  rx_busy
);

  localparam int DIV  = CLK_FREQ_HZ / BAUD;
  localparam int NIBS = 2 * ID_BYTES;
  localparam int NW   = $clog2(NIBS + 1);
  localparam int IW   = 8 * ID_BYTES;

  logic          byte_valid, frame_err, timeout;
  logic [7:0]    byte_data;
  rfid_state_e   state, state_nxt;
  logic [NW-1:0] nib_cnt;
  logic [IW-1:0] id_sh;
  logic [7:0]    cs_sh, xor_acc;
  logic [3:0]    nib;
  logic          restart, id_shift, cs_shift, commit, reject;

  rfid_uart_rx #(.DIV(DIV)) u_uart (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .rx_in      (rx_in),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign nib     = hex2nib(byte_data);
  assign rx_busy = (state != IDLE);

`ifdef RFID_FRAME_RX_TIMEOUT_EN
  localparam int TO_CLKS = 20 * DIV;
  localparam int GW      = $clog2(TO_CLKS + 1);
  logic [GW-1:0] gap;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                        gap <= '0;
    else if (state == IDLE || byte_valid) gap <= '0;
    else                                 gap <= gap + 1'b1;
  end
  assign timeout = (gap == GW'(TO_CLKS - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    id_shift  = 1'b0;
    cs_shift  = 1'b0;
    commit    = 1'b0;
    reject    = 1'b0;
    if (byte_valid) begin
      // STX resynchronises from any state without counting an error.
      if (byte_data == RFID_STX) begin
        restart   = 1'b1;
        state_nxt = DATA;
      end else begin
        case (state)
          DATA: if (is_hex(byte_data)) begin
            id_shift = 1'b1;
            if (nib_cnt == NW'(NIBS - 1)) state_nxt = CSUM;
          end else reject = 1'b1;
          CSUM: if (is_hex(byte_data)) begin
            cs_shift = 1'b1;
            if (nib_cnt == NW'(1)) state_nxt = ETX;
          end else reject = 1'b1;
          ETX: if (byte_data == RFID_ETX && cs_sh == xor_acc) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end else reject = 1'b1;
          default: ;
        endcase
      end
    end else if ((frame_err || timeout) && state != IDLE) begin
      reject = 1'b1;
    end
    if (reject) state_nxt = IDLE;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      nib_cnt <= '0;
      id_sh   <= '0;
      cs_sh   <= '0;
      xor_acc <= '0;
      tag_id  <= '0;
      tag_new <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (restart || (id_shift && state_nxt == CSUM)) nib_cnt <= '0;
      else if (id_shift || cs_shift)                  nib_cnt <= nib_cnt + 1'b1;
      if (id_shift) id_sh <= {id_sh[IW-5:0], nib};
      // Fold each ID byte into the checksum as its second nibble lands.
      if (restart)                     xor_acc <= '0;
      else if (id_shift && nib_cnt[0]) xor_acc <= xor_acc ^ {id_sh[3:0], nib};
      if (cs_shift) cs_sh <= {cs_sh[3:0], nib};
      if (commit) tag_id <= id_sh;
      if (commit)       tag_new <= 1'b1;
      else if (tag_ack) tag_new <= 1'b0;
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rfid_frame_rx.sv
// tb/tb_rfid_frame_rx.sv - directed self-checking bench for rfid_frame_rx
module tb_rfid_frame_rx;

  localparam int DIV = 10;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        rx_in = 1'b1;
  logic        tag_ack = 1'b0;
  logic [39:0] tag_id;
  logic        tag_new;
  logic [7:0]  err_cnt;
  logic        rx_busy;

  int   errors = 0;
  int   checks = 0;
  int   exp_err = 0;
  logic hit;

  always #5 ACLK = ~ACLK;

  rfid_frame_rx #(.CLK_FREQ_HZ(100000000), .BAUD(10000000), .ID_BYTES(5)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .rx_in   (rx_in),
    .tag_ack (tag_ack),
    .tag_id  (tag_id),
    .tag_new (tag_new),
    .err_cnt (err_cnt),
    .rx_busy (rx_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx_in = v;
    repeat (DIV) @(negedge ACLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_frame(input string id, input string cs);
    send_byte(8'h02);
    send_str(id);
    send_str(cs);
    send_byte(8'h03);
  endtask

  task automatic pulse_ack();
    @(negedge ACLK) tag_ack = 1'b1;
    @(negedge ACLK) tag_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge ACLK);
    chk("reset_tag_id", tag_id, 0);
    chk("reset_tag_new", tag_new, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_rx_busy", rx_busy, 0);
    ARESETN = 1'b1;
    repeat (5) @(negedge ACLK);

    send_byte(8'h02);
    chk("busy_after_stx", rx_busy, 1);
    send_str("0123456789");
    send_str("89");
    send_byte(8'h03);
    chk("good_tag_id", tag_id, 40'h0123456789);
    chk("good_tag_new", tag_new, 1);
    chk("good_err_cnt", err_cnt, 0);
    chk("good_rx_busy", rx_busy, 0);

    send_frame("0123456789", "88");
    exp_err = 1;
    chk("badcs_err_cnt", err_cnt, exp_err);
    chk("badcs_tag_id", tag_id, 40'h0123456789);
    chk("badcs_tag_new", tag_new, 1);

    pulse_ack();
    chk("ack_clears", tag_new, 0);
    pulse_ack();
    chk("ack_when_clear", tag_new, 0);

    send_byte(8'h02);
    send_str("01G");
    exp_err = 2;
    chk("nonhex_err_cnt", err_cnt, exp_err);
    chk("nonhex_busy", rx_busy, 0);
    send_frame("abcdef0123", "ab");
    chk("lower_tag_id", tag_id, 40'hABCDEF0123);
    chk("lower_tag_new", tag_new, 1);
    chk("lower_err_cnt", err_cnt, exp_err);

    pulse_ack();
    hit = 1'b0;
    fork
      send_frame("0123456789", "89");
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge ACLK);
          if (dut.commit) begin
            tag_ack = 1'b1;
            @(negedge ACLK) tag_ack = 1'b0;
            hit = 1'b1;
            break;
          end
        end
      end
    join
    chk("ack_commit_seen", hit, 1);
    chk("ack_commit_new", tag_new, 1);
    chk("ack_commit_id", tag_id, 40'h0123456789);

    pulse_ack();
    send_frame("0123456789", "89");
    chk("repeat_id_new", tag_new, 1);

    pulse_ack();
    send_byte(8'h02);
    send_str("01234");
    rx_in = 1'b0;
    repeat (4) @(negedge ACLK);
    rx_in = 1'b1;
    repeat (2 * DIV) @(negedge ACLK);
    send_str("56789");
    send_str("89");
    send_byte(8'h03);
    chk("glitch_tag_new", tag_new, 1);
    chk("glitch_err_cnt", err_cnt, exp_err);

    send_byte(8'h02);
    send_str("01");
    send_byte(8'h35, 1'b0);
    exp_err = 3;
    chk("stop0_err_cnt", err_cnt, exp_err);
    chk("stop0_busy", rx_busy, 0);

    send_byte(8'h02);
    rx_in = 1'b0;
    repeat (40 * DIV) @(negedge ACLK);
    rx_in = 1'b1;
    repeat (3 * DIV) @(negedge ACLK);
    exp_err = 4;
    chk("longlow_err_cnt", err_cnt, exp_err);
    chk("longlow_busy", rx_busy, 0);
    send_frame("abcdef0123", "ab");
    chk("recover_tag_id", tag_id, 40'hABCDEF0123);
    chk("recover_err_cnt", err_cnt, exp_err);

    send_byte(8'h02);
    send_str("012");
    send_frame("0123456789", "89");
    chk("restart_tag_id", tag_id, 40'h0123456789);
    chk("restart_err_cnt", err_cnt, exp_err);

    send_byte(8'h02);
    send_str("0123456789");
    send_str("89");
    send_byte(8'h04);
    exp_err = 5;
    chk("bad_etx_err_cnt", err_cnt, exp_err);

    send_byte(8'h02);
    send_str("01234");
    repeat (30 * DIV) @(negedge ACLK);
`ifdef RFID_FRAME_RX_TIMEOUT_EN
    exp_err = 6;
    chk("timeout_err_cnt", err_cnt, exp_err);
    chk("timeout_busy", rx_busy, 0);
`else
    chk("stall_err_cnt", err_cnt, exp_err);
    chk("stall_busy", rx_busy, 1);
`endif

    @(negedge ACLK) ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    send_str("56789");
    send_str("89");
    send_byte(8'h03);
    chk("midreset_tag_id", tag_id, 0);
    chk("midreset_tag_new", tag_new, 0);
    chk("midreset_err_cnt", err_cnt, 0);
    chk("midreset_busy", rx_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rfid_frame_rx.md
Name: rfid_frame_rx

Overview:
Serial front end of the RFID reader IP. It receives the 8N1 UART byte stream from the external 125 kHz RFID module and parses ASCII tag frames into a binary tag ID, verifying each frame's XOR checksum. It holds the last good ID and a sticky "new tag" flag for the AXI4-Lite register slave directly downstream, which reads the ID and acknowledges it through a register write.

Parameters:
CLK_FREQ_HZ, 100000000, ACLK frequency in Hz.
BAUD, 9600, UART bit rate. Bit divider DIV = CLK_FREQ_HZ/BAUD, integer truncation.
ID_BYTES, 5, binary tag ID length in bytes; the frame carries 2*ID_BYTES ASCII hex characters.

Ports:
ACLK  in  1  system clock, shared with the AXI slave.
ARESETN  in  1  asynchronous active-low reset.
rx_in  in  1  UART line from the RFID module; asynchronous, idles high.
tag_ack  in  1  one-cycle pulse from the register slave; clears tag_new.
tag_id  out  8*ID_BYTES  last valid ID; the first received byte occupies the MSBs.
tag_new  out  1  sticky flag: a valid frame arrived since the last tag_ack.
err_cnt  out  8  count of rejected frames; saturates at 255.
rx_busy  out  1  high while the parser is outside IDLE.

Behaviour:
- Reset (async assert, sync release): tag_id=0, tag_new=0, err_cnt=0, rx_busy=0, parser in IDLE, UART receiver idle. A reset mid-frame discards all partial data.
- UART receiver:
  - rx_in passes through a 2-flop synchroniser whose flops reset to 1.
  - A falling edge in idle starts a counter. After DIV/2 clocks the line is re-sampled; if it is high, the edge is a glitch and the receiver returns to idle.
  - Each of the 8 data bits (LSB first) is sampled every DIV clocks after that, followed by the stop bit.
  - Stop bit = 1: byte_valid pulses for 1 clock with the byte.
  - Stop bit = 0: framing error pulse, no byte_valid. The receiver waits for the line to go high before re-arming.
- Frame format: STX 0x02, then 2*ID_BYTES ASCII hex characters, then 2 ASCII hex checksum characters, then ETX 0x03.
  - Valid hex characters are '0'-'9', 'A'-'F' and 'a'-'f'.
  - The checksum equals the XOR of all ID bytes.
- Parser FSM, advancing on byte_valid:
  - IDLE: STX -> DATA with the nibble counter cleared. Any other byte is ignored, with no error.
  - DATA: hex -> shift the nibble into the ID shift register. After 2*ID_BYTES nibbles -> CSUM.
  - CSUM: two hex nibbles -> ETX.
  - ETX: 0x03 and checksum match -> commit, then IDLE. A checksum mismatch, or any byte other than 0x03 -> reject, then IDLE.
  - In DATA, CSUM or ETX, a non-hex byte rejects the frame, except STX, which silently restarts in DATA with no error.
  - A framing error while the parser is not in IDLE rejects the frame.
- Commit: on the clock after the ETX byte_valid, tag_id is loaded and tag_new=1. The running XOR is accumulated per completed byte, so no wide compare is needed.
- Reject: err_cnt increments by 1 (holds at 255) and tag_id and tag_new are unchanged.
- tag_ack and a commit in the same cycle: the commit wins, so tag_new stays 1. tag_ack while tag_new=0 has no effect.
- A repeated identical ID still commits and sets tag_new again.
- rx_busy is high in DATA, CSUM and ETX.

Optional Feature:
RFID_FRAME_RX_TIMEOUT_EN.
- Defined: a gap counter runs while the parser is outside IDLE and clears on every byte_valid. If it reaches 20*DIV clocks (about 2 character times), the frame is rejected (err_cnt +1) and the parser returns to IDLE.
- Undefined: there is no gap counter, and the parser waits indefinitely in a partial frame.

Decomposition:
- Package rfid_pkg holds:
  - localparams RFID_STX=8'h02 and RFID_ETX=8'h03;
  - the parser state enum (IDLE, DATA, CSUM, ETX);
  - function is_hex(byte) returning a bit;
  - function hex2nib(byte) returning 4 bits.
- Sub-module rfid_uart_rx contains the synchroniser, bit counter and baud timer. It outputs byte_valid, byte_data and frame_err, and is parameterised by DIV.

Test Plan:
- Defaults (DIV=10416). Send 02 "0123456789" "89" 03 -> tag_id=40'h0123456789 and tag_new=1, one clock after the ETX stop sample; err_cnt=0.
- Same frame with checksum "88" -> err_cnt=1, tag_id keeps its previous value, tag_new unchanged.
- Send 02 "01G3..." -> reject at 'G': err_cnt+1, parser in IDLE (rx_busy=0) by the next clock. Then a valid frame with lowercase "abcdef0123" and checksum "ab" -> tag_id=40'hABCDEF0123.
- After a commit, pulse tag_ack -> tag_new=0. Pulse tag_ack in the same cycle as a commit -> tag_new=1.
- Send a 40 ns low glitch on rx_in -> no byte_valid. Send a byte with stop bit 0 mid-frame -> err_cnt+1. Hold rx_in low for 1 ms -> only one framing event is counted.
- Assert ARESETN low mid-frame, then complete the frame -> outputs stay 0 and no commit occurs. With TIMEOUT_EN defined, stall 3 character times after STX -> err_cnt+1, rx_busy=0.
